alu_decode: RTL

Operand and opcode producer for `alu`. Sits between register-file read and the ALU. Accepts one RV32I instruction per beat together with its PC and register read data. Emits a registered `{op1, op2, aluop}` bundle with writeback tags over a valid/ready handshake. It is the driving end of the ALU's `i_op1`/`i_op2`/`i_aluop` interface and owns the opcode encoding that `alu` consumes.

---
 rtl/alu_pkg.sv | 38 +++
 rtl/alu_skid_buffer.sv | 49 ++++
 rtl/alu_decode.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU encodings: opcode enum, RV32I major opcodes, funct7 constants
// and the operand bundle passed from alu_decode to alu.
package alu_pkg;

    localparam int ALU_DATA_W = 32;
    localparam int ALU_OP_W   = 4;

    // Bit 0 picks arithmetic in the shifter: SRA odd, SRL even.
    typedef enum logic [ALU_OP_W-1:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_SLL  = 4'b0010,
        ALU_XOR  = 4'b0011,
        ALU_OR   = 4'b0100,
        ALU_AND  = 4'b0101,
        ALU_PASS = 4'b0110,
        ALU_SRA  = 4'b0111,
        ALU_SRL  = 4'b1000
    } aluop_e;

    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef struct packed {
        logic [ALU_DATA_W-1:0] op1;
        logic [ALU_DATA_W-1:0] op2;
        aluop_e                aluop;
        logic [4:0]            rd;
        logic                  we;
        logic                  illegal;
    } alu_bundle_t;

endpackage

// File: rtl/alu_skid_buffer.sv
// Output register plus one skid entry. s_ready is purely registered (skid
// empty), so upstream never sees a combinational path from m_ready.
module alu_skid_buffer
    import alu_pkg::*;
#(
    parameter type T = alu_bundle_t
) (
    input  logic clk,
    input  logic reset_n,
    input  logic s_valid,
    output logic s_ready,
    input  T     s_data,
    output logic m_valid,
    input  logic m_ready,
    output T     m_data
);

    logic skid_valid;
    T     skid_data;
    logic accept;

    assign s_ready = !skid_valid;
    assign accept  = s_valid && s_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_valid    <= 1'b0;
            m_data     <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
        end else if (!m_valid || m_ready) begin
            // The skid entry is older than anything upstream, so it drains first.
            if (skid_valid) begin
                m_valid    <= 1'b1;
                m_data     <= skid_data;
                skid_valid <= 1'b0;
            end else begin
                m_valid <= accept;
                if (accept) begin
                    m_data <= s_data;
                end
            end
        end else if (accept) begin
            skid_valid <= 1'b1;
            skid_data  <= s_data;
        end
    end

endmodule

// File: rtl/alu_decode.sv
// RV32I decode to {op1, op2, aluop} for alu, registered behind valid/ready.
// ALU_DECODE_SKID_EN adds a skid entry and makes o_ready fully registered.
module alu_decode
    import alu_pkg::*;
#(
    parameter int DWIDTH      = ALU_DATA_W,
    parameter int ALUOP_WIDTH = ALU_OP_W
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   i_valid,
    output logic                   o_ready,
    input  logic [31:0]            i_instr,
    input  logic [DWIDTH-1:0]      i_pc,
    input  logic [DWIDTH-1:0]      i_rs1_data,
    input  logic [DWIDTH-1:0]      i_rs2_data,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic [DWIDTH-1:0]      o_op1,
    output logic [DWIDTH-1:0]      o_op2,
    output logic [ALUOP_WIDTH-1:0] o_aluop,
    output logic [4:0]             o_rd,
    output logic                   o_we,
    output logic                   o_illegal
);

    logic [6:0]        opcode;
    logic [2:0]        f3;
    logic [6:0]        f7;
    logic [DWIDTH-1:0] imm_i;
    logic [DWIDTH-1:0] imm_u;

    assign opcode = i_instr[6:0];
    assign f3     = i_instr[14:12];
    assign f7     = i_instr[31:25];
    assign imm_i  = {{(DWIDTH-12){i_instr[31]}}, i_instr[31:20]};
    assign imm_u  = {i_instr[31:12], 12'b0};

    logic              legal;
    aluop_e            aluop;
    logic [DWIDTH-1:0] op1;
    logic [DWIDTH-1:0] op2;
    alu_bundle_t       dec;

    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        legal = 1'b1;
        aluop = ALU_ADD;
        op1   = i_rs1_data;
        op2   = i_rs2_data;
        case (opcode)
            OP: begin
                case (f3)
                    3'b000: begin
                        if (f7 == F7_ALT) aluop = ALU_SUB;
                        legal = (f7 == F7_BASE) || (f7 == F7_ALT);
                    end
                    3'b001: begin aluop = ALU_SLL; legal = (f7 == F7_BASE); end
                    3'b100: begin aluop = ALU_XOR; legal = (f7 == F7_BASE); end
                    3'b110: begin aluop = ALU_OR;  legal = (f7 == F7_BASE); end
                    3'b111: begin aluop = ALU_AND; legal = (f7 == F7_BASE); end
                    3'b101: begin
                        aluop = (f7 == F7_ALT) ? ALU_SRA : ALU_SRL;
                        legal = (f7 == F7_BASE) || (f7 == F7_ALT);
                    end
                    default: legal = 1'b0;
                endcase
            end
            OP_IMM: begin
                op2 = imm_i;
                case (f3)
                    3'b000: aluop = ALU_ADD;
                    3'b100: aluop = ALU_XOR;
                    3'b110: aluop = ALU_OR;
                    3'b111: aluop = ALU_AND;
                    3'b001: begin aluop = ALU_SLL; legal = (f7 == F7_BASE); end
                    3'b101: begin
                        aluop = (f7 == F7_ALT) ? ALU_SRA : ALU_SRL;
                        legal = (f7 == F7_BASE) || (f7 == F7_ALT);
                    end
                    default: legal = 1'b0;
                endcase
            end
            LUI: begin
                op1   = '0;
                op2   = imm_u;
                aluop = ALU_PASS;
            end
            AUIPC: begin
                op1 = i_pc;
                op2 = imm_u;
            end
            default: legal = 1'b0;
        endcase

        // Illegal beats still flow, but as an inert ADD 0,0 with no writeback.
        dec         = '0;
        dec.rd      = i_instr[11:7];
        dec.illegal = !legal;
        if (legal) begin
            dec.op1   = op1;
            dec.op2   = op2;
            dec.aluop = aluop;
            dec.we    = (i_instr[11:7] != 5'd0);
        end
    end

    alu_bundle_t out_q;

`ifdef ALU_DECODE_SKID_EN
    alu_skid_buffer #(
        .T(alu_bundle_t)
    ) u_skid (
        .clk     (clk),
        .reset_n (reset_n),
        .s_valid (i_valid),
        .s_ready (o_ready),
        .s_data  (dec),
        .m_valid (o_valid),
        .m_ready (i_ready),
        .m_data  (out_q)
    );
`else
    assign o_ready = !o_valid || i_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            o_valid <= 1'b0;
            // NOTE: the data register is reset too, because every output must read 0 in reset.
            out_q   <= '0;
        end else if (o_ready) begin
            // NOTE: non-blocking assignments keep all flops sampling pre-edge values.
            o_valid <= i_valid;
            if (i_valid) begin
                out_q <= dec;
            end
        end
    end
`endif

    assign o_op1     = out_q.op1;
    assign o_op2     = out_q.op2;
    assign o_aluop   = out_q.aluop;
    assign o_rd      = out_q.rd;
    assign o_we      = out_q.we;
    assign o_illegal = out_q.illegal;

endmodule
